// File: rtl/regfile_sb_pkg.sv
// Shared sizes and types for the integer register file and its pending-write scoreboard.
package regfile_sb_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;
   localparam int SBW    = 2;

   typedef logic [REG_AW-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]   xdata_t;
   typedef logic [SBW-1:0]    sb_cnt_t;

   localparam reg_idx_t X0      = '0;
   localparam sb_cnt_t  CNT_MAX = '1;

   // One scoreboard event (issue, retire or cancel) aimed at a register.
   typedef struct packed {
      logic     vld;
      reg_idx_t rd;
   } sb_req_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of in-flight writers; reports busy sources and a saturated destination.
module reg_scoreboard
   import regfile_sb_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  sb_req_t  issue,
   input  sb_req_t  retire,
   input  sb_req_t  cancel,
   input  reg_idx_t rs1_addr,
   input  reg_idx_t rs2_addr,
   input  reg_idx_t chk_rd,
   output logic     busy1,
   output logic     busy2,
   output logic     full
);
   logic [NREG-1:0][SBW-1:0] cnt;
   logic [NREG-1:0][1:0]     dec;

   assign cnt[0] = '0;
   assign dec[0] = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      logic          inc, dw, dc;
      logic [SBW:0]  up, dn;
      sb_cnt_t       c;

      assign inc    = issue.vld  && (issue.rd  == reg_idx_t'(r));
      assign dw     = retire.vld && (retire.rd == reg_idx_t'(r));
      assign dc     = cancel.vld && (cancel.rd == reg_idx_t'(r));
      assign dec[r] = {1'b0, dw} + {1'b0, dc};
      assign up     = {1'b0, c} + {{SBW{1'b0}}, inc};
      assign dn     = {{(SBW-1){1'b0}}, dec[r]};
      assign cnt[r] = c;

      // Decrement past zero is a protocol error upstream; hold at zero.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            c <= '0;
         end else begin
            assert (dn <= up);
            if (dn > up) c <= '0;
            else         c <= sb_cnt_t'(up - dn);
         end
      end
   end

   // A writer retiring or cancelled this cycle no longer counts against readers.
   assign busy1 = {1'b0, cnt[rs1_addr]} > {{(SBW-1){1'b0}}, dec[rs1_addr]};
   assign busy2 = {1'b0, cnt[rs2_addr]} > {{(SBW-1){1'b0}}, dec[rs2_addr]};
   assign full  = (cnt[chk_rd] == CNT_MAX) && (dec[chk_rd] == 2'd0);
endmodule

// File: rtl/regfile_sb.sv
// x1..x31 storage with same-cycle writeback bypass, plus decode stall/issue glue around the scoreboard.
module regfile_sb
   import regfile_sb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_write,
   input  logic [31:0]     write_addr,
   input  logic [XLEN-1:0] write_data,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic            rs1_used,
   input  logic            rs2_used,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            cancel_valid,
   input  logic [4:0]      cancel_rd,
   output logic            hazard_stall,
   output logic            issue_ack
);
   reg_idx_t               wb_rd;
   logic                   unused_addr_hi;
   logic [NREG-1:0][XLEN-1:0] regs;
   logic                   busy1, busy2, full;

   assign wb_rd          = write_addr[REG_AW-1:0];
   assign unused_addr_hi = ^write_addr[31:REG_AW];
   assign regs[0]        = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_reg
      xdata_t q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                                    q <= '0;
         else if (op_write && wb_rd == reg_idx_t'(r))  q <= write_data;
      end
      assign regs[r] = q;
   end

   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == X0)                      rs1_data = '0;
      else if (op_write && wb_rd == rs1_addr)  rs1_data = write_data;
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == X0)                      rs2_data = '0;
      else if (op_write && wb_rd == rs2_addr)  rs2_data = write_data;
   end

   reg_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    ('{vld: issue_ack,    rd: issue_rd}),
      .retire   ('{vld: op_write,     rd: wb_rd}),
      .cancel   ('{vld: cancel_valid, rd: cancel_rd}),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .chk_rd   (issue_rd),
      .busy1    (busy1),
      .busy2    (busy2),
      .full     (full)
   );

   // full is already false for x0, so issuing to x0 never stalls on saturation.
   assign hazard_stall = (rs1_used && busy1) || (rs2_used && busy2) || (issue_valid && full);
   assign issue_ack    = issue_valid && !hazard_stall && (issue_rd != X0);
endmodule
